cpu_trace_buffer: RTL
=====================

// Module: cpu_trace_buffer
// PURPOSE
//  Synthesizable commit-trace capture unit for the single-cycle CPU.
//  Records one entry per retired instruction: cycle stamp, PC, write kind, write address, write data.
//  Supports PC-match trigger with post-trigger depth, plus stop-when-full or wrap (ring) mode.
//  Sits beside the CPU core; frozen trace is drained over a valid/ready port by a debug reader.
// PARAMETERS
//  PC_W      16  PC width
//  DATA_W    16  RF/DM data width; also address field width
//  RADDR_W    3  register-file address width (zero-extended into address field)
//  DEPTH     32  buffer entries, power of 2, >=2
//  CNT_W     16  cycle-stamp width
//  POST_TRIG  8  records captured after the trigger record (0 = stop on trigger)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous active-high reset
//  en           in   1       arm capture (level); falling in ARMED/POST freezes trace
//  clr          in   1       pulse: DONE->IDLE, empties buffer
//  cfg_wrap     in   1       1 = ring mode, 0 = stop when full; sampled on IDLE->ARMED
//  trig_en      in   1       enable PC-match trigger
//  trig_pc      in   PC_W    trigger PC
//  commit_valid in   1       instruction retires this cycle
//  commit_pc    in   PC_W    PC of retiring instruction
//  rf_we        in   1       retiring instruction writes RF
//  rf_waddr     in   RADDR_W RF write address
//  rf_wdata     in   DATA_W  RF write data
//  dm_we        in   1       retiring instruction writes data memory
//  dm_waddr     in   DATA_W  DM write address
//  dm_wdata     in   DATA_W  DM write data
//  rd_valid     out  1       oldest record available (DONE only)
//  rd_ready     in   1       reader accepts record
//  rd_data      out  REC_W   {stamp[CNT_W], pc[PC_W], kind[2], addr[DATA_W], data[DATA_W]}
//  count        out  log2(DEPTH)+1  entries held
//  state        out  2       00 IDLE, 01 ARMED, 10 POST, 11 DONE
//  overflow     out  1       sticky: ring mode overwrote an entry
//  conflict     out  1       sticky: rf_we and dm_we on same commit
// BEHAVIOUR
//  Reset: state=IDLE, count=0, wr/rd ptrs=0, stamp=0, overflow=0, conflict=0, rd_valid=0, rd_data=0.
//  kind: 00 none, 01 RF, 10 DM; rf_we&dm_we -> RF recorded (kind 01), conflict set.
//  RF addr zero-extended to DATA_W. kind 00 -> addr/data fields zero.
//  IDLE: en=1 -> ARMED next cycle; stamp, ptrs, count, flags cleared; cfg_wrap latched.
//  Stamp: increments every cycle in ARMED/POST, saturates at 2^CNT_W-1; 0 on first ARMED cycle.
//  ARMED/POST: commit_valid writes record with current stamp at wr_ptr; ptr wraps mod DEPTH.
//  Write latency: record visible in count the cycle after commit.
//  Full, no-wrap: the DEPTH-th write -> DONE next cycle; no further writes.
//  Full, wrap: write overwrites oldest, rd_ptr advances, count stays DEPTH, overflow=1.
//  ARMED: trig_en & commit_valid & commit_pc==trig_pc -> trigger record written;
//   POST_TRIG=0 -> DONE, else POST with remaining=POST_TRIG.
//  POST: each commit writes and decrements remaining; write at remaining==1 -> DONE.
//  Trigger ignored in POST; only first match counts.
//  en=0 in ARMED/POST -> DONE next cycle; a commit in that same cycle is still captured.
//  DONE: no capture; rd_valid=(count!=0); rd_data=entry[rd_ptr], combinational from buffer.
//  rd_data stable while rd_valid & !rd_ready.
//  rd_valid & rd_ready pops: rd_ptr+1, count-1. Draining does not leave DONE.
//  DONE + clr -> IDLE next cycle, count=0, flags kept until next arm; clr ignored elsewhere.
//  rst in any state, including mid-drain, overrides all: reset values next cycle.
// TESTING (DEPTH=4, POST_TRIG=2, CNT_W=16 unless noted)
//  1 rst 2 cyc, en=1, trig_en=0, wrap=0, 6 commits pc=0..5 every cycle
//    -> DONE after 4th; drain gives pc 0,1,2,3, stamps 0,1,2,3; count 4->0.
//  2 wrap=1, 6 commits pc=0..5, then en=0
//    -> overflow=1, count=4; drain pc 2,3,4,5.
//  3 wrap=1, trig_en=1, trig_pc=3, commits pc=0..7
//    -> DONE after pc 5; drain pc 2,3,4,5; pc 6,7 not captured.
//  4 commit pc=1, rf_we waddr=7 wdata=0x00AB, dm_we waddr=3 wdata=0x0011
//    -> kind=01, addr=7, data=0x00AB, conflict=1.
//  5 DONE with 3 entries; rd_ready held 0 for 3 cycles then 1
//    -> rd_data constant while stalled; then 3 pops, rd_valid=0; clr -> state=IDLE.
//  6 rst=1 mid-drain (count=2)
//    -> next cycle state=IDLE, count=0, rd_valid=0, overflow=0, stamp=0.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture unit: records one entry per retired instruction, with a PC-match
// trigger, post-trigger depth, stop-when-full or ring mode, and a valid/ready drain port.
module cpu_trace_buffer #(
    parameter int PC_W      = 16,
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 3,
    parameter int DEPTH     = 32,
    parameter int CNT_W     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  clr,
    input  logic                                  cfg_wrap,
    input  logic                                  trig_en,
    input  logic [PC_W-1:0]                       trig_pc,
    input  logic                                  commit_valid,
    input  logic [PC_W-1:0]                       commit_pc,
    input  logic                                  rf_we,
    input  logic [RADDR_W-1:0]                    rf_waddr,
    input  logic [DATA_W-1:0]                     rf_wdata,
    input  logic                                  dm_we,
    input  logic [DATA_W-1:0]                     dm_waddr,
    input  logic [DATA_W-1:0]                     dm_wdata,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic [CNT_W+PC_W+2+2*DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]                count,
    output logic [1:0]                            state,
    output logic                                  overflow,
    output logic                                  conflict
);

    localparam int REC_W = CNT_W + PC_W + 2 + 2 * DATA_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REM_W = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt;
    logic [CNT_W-1:0]    stamp;
    logic                wrap_q;
    logic [REM_W-1:0]    remaining;
    logic                ovf_q, conf_q;
    logic [REC_W-1:0]    mem [DEPTH];

    logic                capturing;
    logic                full;
    logic                last_slot;
    logic                wr_en;
    logic                trig_hit;
    logic                pop;
    logic [1:0]          rec_kind;
    logic [DATA_W-1:0]   rec_addr, rec_data;
    logic [REC_W-1:0]    rec;

    assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
    assign full      = (cnt == CW'(DEPTH));
    assign last_slot = !wrap_q && (cnt == CW'(DEPTH - 1));
    assign wr_en     = capturing && commit_valid && (wrap_q || !full);
    assign trig_hit  = (state_q == S_ARMED) && trig_en && commit_valid && (commit_pc == trig_pc);

    // Read port: a record transfers on every clock where rd_valid and rd_ready are both high;
    // while rd_valid is high and rd_ready low, rd_data holds the same oldest record.
    assign pop = (state_q == S_DONE) && rd_valid && rd_ready && !clr;

    // An RF write wins over a simultaneous DM write; the collision is flagged separately.
    always_comb begin
        rec_kind = 2'b00;
        rec_addr = '0;
        rec_data = '0;
        if (rf_we) begin
            rec_kind = 2'b01;
            rec_addr = DATA_W'(rf_waddr);
            rec_data = rf_wdata;
        end else if (dm_we) begin
            rec_kind = 2'b10;
            rec_addr = dm_waddr;
            rec_data = dm_wdata;
        end
        rec = {stamp, commit_pc, rec_kind, rec_addr, rec_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!en || (wr_en && last_slot)) begin
                    state_d = S_DONE;
                end else if (trig_hit) begin
                    state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (!en || (wr_en && (last_slot || remaining == REM_W'(1)))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (clr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            stamp     <= '0;
            wrap_q    <= 1'b0;
            remaining <= '0;
            ovf_q     <= 1'b0;
            conf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        cnt    <= '0;
                        stamp  <= '0;
                        ovf_q  <= 1'b0;
                        conf_q <= 1'b0;
                        wrap_q <= cfg_wrap;
                    end
                end
                S_ARMED, S_POST: begin
                    if (stamp != '1) begin
                        stamp <= stamp + 1'b1;
                    end
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // Ring mode at capacity: the oldest entry is overwritten.
                        if (full) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            ovf_q  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (rf_we && dm_we) begin
                            conf_q <= 1'b1;
                        end
                    end
                    if (trig_hit) begin
                        remaining <= REM_W'(POST_TRIG);
                    end else if ((state_q == S_POST) && wr_en) begin
                        remaining <= remaining - 1'b1;
                    end
                end
                S_DONE: begin
                    if (clr) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        cnt    <= '0;
                    end else if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        cnt    <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= rec;
        end
    end

    assign state    = state_q;
    assign count    = cnt;
    assign rd_valid = (state_q == S_DONE) && (cnt != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign overflow = ovf_q;
    assign conflict = conf_q;

endmodule
